// File: rtl/multimem_wr_sched_pkg.sv
// Shared types and geometry for the multimem port-A write scheduler.
package multimem_wr_sched_pkg;

   localparam int unsigned PIXEL_WIDTH     = 64;
   localparam int unsigned PIXEL_HEIGHT    = 64;
   localparam int unsigned BYTES_PER_PIXEL = 1;
   localparam int unsigned MEM_DEPTH       = PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL;
   localparam int unsigned MEM_ADDR_W      = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StDone
   } sched_state_e;

   typedef enum logic [1:0] {
      GntNone,
      GntStream,
      GntClear
   } grant_e;

endpackage

// File: rtl/multimem_wr_arb2.sv
// Two-requester weighted arbiter: stream may take up to FAIR_CNT back-to-back grants
// while the clear engine is waiting, then clear gets one.
module multimem_wr_arb2
   import multimem_wr_sched_pkg::*;
#(
   parameter int unsigned FAIR_CNT = 1
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   req_stream_i,
   input  logic   req_clear_i,
   output grant_e grant_o
);

   localparam logic [3:0] FairMax = 4'(FAIR_CNT);

   logic [3:0] fair_q, fair_d;

   // Grant decision and consecutive-stream-grant counter update.
   always_comb begin
      grant_o = GntNone;
      fair_d  = '0;
      if (req_stream_i && req_clear_i) begin
         if (fair_q < FairMax) begin
            grant_o = GntStream;
            fair_d  = fair_q + 4'd1;
         end else begin
            grant_o = GntClear;
         end
      end else if (req_stream_i) begin
         grant_o = GntStream;
         // Saturate so a long stream-only burst cannot wrap the counter.
         fair_d  = (fair_q < FairMax) ? fair_q + 4'd1 : fair_q;
      end else if (req_clear_i) begin
         grant_o = GntClear;
      end
   end

   // Counter register; clears on clear grants and idle cycles via fair_d default.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fair_q <= '0;
      end else begin
         fair_q <= fair_d;
      end
   end

endmodule

// File: rtl/multimem_wr_sched.sv
// Port-A write scheduler: shares the byte-wide RAM write port between a pixel stream
// and a whole-RAM clear engine, with a registered RAM-port mux.
module multimem_wr_sched
   import multimem_wr_sched_pkg::*;
#(
   parameter int unsigned DEPTH    = MEM_DEPTH,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned FAIR_CNT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [7:0]        s_data,
   input  logic              clr_start,
   input  logic [7:0]        clr_value,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_ce,
   output logic              ram_wr
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   sched_state_e      state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        val_q, val_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_data_q, ram_data_d;
   logic              ram_ce_q, ram_ce_d;
   grant_e            grant;
   logic              req_stream;
   logic              req_clear;

   // Gating with reset_n keeps s_ready low while reset is asserted.
   assign req_stream = s_valid & reset_n;
   assign req_clear  = (state_q == StClear);

   multimem_wr_arb2 #(
      .FAIR_CNT (FAIR_CNT)
   ) u_arb (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_stream_i (req_stream),
      .req_clear_i  (req_clear),
      .grant_o      (grant)
   );

   // Clear FSM next state, pointer advance and fill-value capture.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      val_d   = val_q;
      case (state_q)
         StIdle: begin
            if (clr_start) begin
               state_d = StClear;
               ptr_d   = '0;
               val_d   = clr_value;
            end
         end
         StClear: begin
            if (grant == GntClear) begin
               if (ptr_q == LastAddr) begin
                  state_d = StDone;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // RAM-port mux: winner's address/data registered; addr/data hold when nobody wins.
   always_comb begin
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      ram_ce_d   = 1'b0;
      case (grant)
         GntStream: begin
            ram_addr_d = s_addr;
            ram_data_d = s_data;
            ram_ce_d   = 1'b1;
         end
         GntClear: begin
            ram_addr_d = ptr_q;
            ram_data_d = val_q;
            ram_ce_d   = 1'b1;
         end
         default: begin
            ram_ce_d = 1'b0;
         end
      endcase
   end

   // State, pointer and RAM-port registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         val_q      <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_ce_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         val_q      <= val_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         ram_ce_q   <= ram_ce_d;
      end
   end

   assign s_ready  = (grant == GntStream);
   assign clr_busy = (state_q != StIdle);
   assign clr_done = (state_q == StDone);
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_ce   = ram_ce_q;
   assign ram_wr   = ram_ce_q;

endmodule

// File: tb/tb_multimem_wr_sched.sv
// Self-checking bench for multimem_wr_sched: table vectors, directed clear/contention/reset
// sequences and a randomized run against a behavioural model with a RAM image.
module tb_multimem_wr_sched;

   localparam int DEPTH  = 4096;
   localparam int ADDR_W = 12;
   localparam int FAIR   = 1;

   logic              clk;
   logic              reset_n;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] s_addr;
   logic [7:0]        s_data;
   logic              clr_start;
   logic [7:0]        clr_value;
   logic              clr_busy;
   logic              clr_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_data;
   logic              ram_ce;
   logic              ram_wr;

   multimem_wr_sched #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .FAIR_CNT (FAIR)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_addr    (s_addr),
      .s_data    (s_data),
      .clr_start (clr_start),
      .clr_value (clr_value),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_ce    (ram_ce),
      .ram_wr    (ram_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side RAM standing in for multimem port A.
   logic [7:0] ram [DEPTH];
   always @(posedge clk) begin
      if (ram_ce && ram_wr) ram[ram_addr] <= ram_data;
   end

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   bit         m_clearing;
   bit         m_done;
   int         m_next;
   int         m_streak;
   logic [7:0] m_val;
   logic [11:0] m_last_addr;
   logic [7:0] m_last_data;
   logic [7:0] m_ram [DEPTH];

   int n_busy, n_done, n_sgnt, n_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clearing  = 1'b0;
      m_done      = 1'b0;
      m_next      = 0;
      m_streak    = 0;
      m_val       = 8'h00;
      m_last_addr = '0;
      m_last_data = '0;
   endtask

   task automatic clr_counts();
      n_busy = 0; n_done = 0; n_sgnt = 0; n_wr = 0;
   endtask

   // One clock cycle: drive at negedge, check handshake, check registered port after posedge.
   task automatic cycle(input logic v, input logic [11:0] a, input logic [7:0] d,
                        input logic cs, input logic [7:0] cv,
                        output logic o_rdy, output logic o_ce,
                        output logic [11:0] o_addr, output logic [7:0] o_data);
      bit g_s, g_c;
      s_valid = v; s_addr = a; s_data = d; clr_start = cs; clr_value = cv;
      #1;
      g_s = 1'b0; g_c = 1'b0;
      if (v && m_clearing) begin
         if (m_streak < FAIR) g_s = 1'b1;
         else                 g_c = 1'b1;
      end else if (v) begin
         g_s = 1'b1;
      end else if (m_clearing) begin
         g_c = 1'b1;
      end
      o_rdy = s_ready;
      chk("s_ready", 32'(s_ready), 32'(g_s));
      chk("clr_busy", 32'(clr_busy), 32'(m_clearing | m_done));
      chk("clr_done", 32'(clr_done), 32'(m_done));
      if (clr_busy) n_busy++;
      if (clr_done) n_done++;
      if (s_ready)  n_sgnt++;
      @(posedge clk);
      #1;
      if (g_s) begin
         m_last_addr = a; m_last_data = d; m_ram[a] = d;
         m_streak = (m_streak < FAIR) ? m_streak + 1 : m_streak;
      end else if (g_c) begin
         m_last_addr = 12'(m_next); m_last_data = m_val; m_ram[m_next] = m_val;
         m_streak = 0;
      end else begin
         m_streak = 0;
      end
      o_ce = ram_ce; o_addr = ram_addr; o_data = ram_data;
      chk("ram_ce", 32'(ram_ce), 32'(g_s | g_c));
      chk("ram_wr", 32'(ram_wr), 32'(g_s | g_c));
      chk("ram_addr", 32'(ram_addr), 32'(m_last_addr));
      chk("ram_data", 32'(ram_data), 32'(m_last_data));
      if (ram_ce) n_wr++;
      if (m_done) begin
         m_done = 1'b0;
      end else if (m_clearing) begin
         if (g_c) begin
            if (m_next == DEPTH - 1) begin
               m_clearing = 1'b0;
               m_done     = 1'b1;
            end else begin
               m_next++;
            end
         end
      end else if (cs) begin
         m_clearing = 1'b1; m_next = 0; m_val = cv;
      end
      @(negedge clk);
   endtask

   task automatic step(input logic v, input logic [11:0] a, input logic [7:0] d,
                       input logic cs, input logic [7:0] cv);
      logic r, ce; logic [11:0] ad; logic [7:0] dt;
      cycle(v, a, d, cs, cv, r, ce, ad, dt);
   endtask

   // Run until the model says the clear has finished (bounded).
   task automatic run_clear(input bit stream_on, input int bound);
      int k;
      k = 0;
      while ((m_clearing || m_done) && k < bound) begin
         step(stream_on & m_clearing, 12'($urandom_range(1, DEPTH - 1)), 8'($urandom), 1'b0, 8'h00);
         k++;
      end
      chk("clear_bound", 32'(m_clearing | m_done), 32'd0);
   endtask

   task automatic image_check(input string name);
      int mism;
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== m_ram[i]) mism++;
      chk(name, 32'(mism), 32'd0);
   endtask

   task automatic all_value_check(input string name, input logic [7:0] val);
      int mism;
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== val) mism++;
      chk(name, 32'(mism), 32'd0);
   endtask

   typedef struct {
      logic        v;
      logic [11:0] a;
      logic [7:0]  d;
      logic        exp_rdy;
      logic        exp_ce;
      logic [11:0] exp_addr;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t tbl [5];

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic r, ce; logic [11:0] ad; logic [7:0] dt;

      tbl[0] = '{1'b1, 12'hFFF, 8'h41, 1'b1, 1'b1, 12'hFFF, 8'h41};
      tbl[1] = '{1'b1, 12'hFFE, 8'h42, 1'b1, 1'b1, 12'hFFE, 8'h42};
      tbl[2] = '{1'b0, 12'h123, 8'h55, 1'b0, 1'b0, 12'hFFE, 8'h42};
      tbl[3] = '{1'b1, 12'h010, 8'h51, 1'b1, 1'b1, 12'h010, 8'h51};
      tbl[4] = '{1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h010, 8'h51};

      // Reset held with stream valid: everything quiet.
      reset_n = 1'b0; s_valid = 1'b1; s_addr = 12'hABC; s_data = 8'h5A;
      clr_start = 1'b0; clr_value = 8'h00;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_s_ready", 32'(s_ready), 32'd0);
         chk("rst_ram_ce", 32'(ram_ce | ram_wr), 32'd0);
         chk("rst_ram_addr", 32'(ram_addr), 32'd0);
         chk("rst_ram_data", 32'(ram_data), 32'd0);
         chk("rst_clr", 32'({clr_busy, clr_done}), 32'd0);
      end
      reset_n = 1'b1;
      clr_counts();

      // Stream-only vectors.
      for (int i = 0; i < 5; i++) begin
         cycle(tbl[i].v, tbl[i].a, tbl[i].d, 1'b0, 8'h00, r, ce, ad, dt);
         chk("tbl_ready", 32'(r), 32'(tbl[i].exp_rdy));
         chk("tbl_ce", 32'(ce), 32'(tbl[i].exp_ce));
         chk("tbl_addr", 32'(ad), 32'(tbl[i].exp_addr));
         chk("tbl_data", 32'(dt), 32'(tbl[i].exp_data));
      end
      chk("ram_fff", 32'(ram[12'hFFF]), 32'h41);
      chk("ram_ffe", 32'(ram[12'hFFE]), 32'h42);

      // Plain clear with no stream traffic.
      clr_counts();
      step(1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
      run_clear(1'b0, DEPTH + 10);
      chk("clear_busy_cycles", 32'(n_busy), 32'(DEPTH + 1));
      chk("clear_writes", 32'(n_wr), 32'(DEPTH));
      chk("clear_done_pulses", 32'(n_done), 32'd1);
      step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      all_value_check("clear_all_zero", 8'h00);

      // Contention: first stream byte to addr 0 is overwritten by the later clear byte.
      clr_counts();
      step(1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
      step(1'b1, 12'h000, 8'h59, 1'b0, 8'h00);
      run_clear(1'b1, 2 * DEPTH + 10);
      chk("contend_busy_cycles", 32'(n_busy), 32'(2 * DEPTH + 1));
      chk("contend_stream_grants", 32'(n_sgnt), 32'(DEPTH));
      chk("contend_done_pulses", 32'(n_done), 32'd1);
      step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      chk("addr0_cleared", 32'(ram[0]), 32'h00);
      step(1'b1, 12'h000, 8'h5A, 1'b0, 8'h00);
      step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      chk("z_after_clear", 32'(ram[0]), 32'h5A);
      image_check("contend_image");

      // Restart attempt mid-clear must be ignored.
      clr_counts();
      step(1'b0, 12'h000, 8'h00, 1'b1, 8'h00);
      for (int i = 0; i < 50; i++) step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      step(1'b0, 12'h000, 8'h00, 1'b1, 8'hFF);
      run_clear(1'b0, DEPTH + 10);
      chk("restart_done_pulses", 32'(n_done), 32'd1);
      chk("restart_writes", 32'(n_wr), 32'(DEPTH));
      step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      all_value_check("restart_all_zero", 8'h00);

      // Reset mid-clear at ptr=100.
      step(1'b0, 12'h000, 8'h00, 1'b1, 8'hA5);
      for (int i = 0; i < 100; i++) step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      s_valid = 1'b1; s_addr = 12'h321;
      #2 reset_n = 1'b0;
      #1;
      chk("abort_s_ready", 32'(s_ready), 32'd0);
      chk("abort_ram_ce", 32'(ram_ce | ram_wr), 32'd0);
      chk("abort_ram_addr", 32'(ram_addr), 32'd0);
      chk("abort_ram_data", 32'(ram_data), 32'd0);
      chk("abort_clr", 32'({clr_busy, clr_done}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      clr_counts();
      for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      chk("abort_no_done", 32'(n_done), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 12'($urandom), 8'($urandom),
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 8'($urandom));
      end
      run_clear(1'b0, DEPTH + 10);
      step(1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
      image_check("random_image");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
